// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer:
// opcodes, IR field positions, FSM states and register selectors.
package cpu_ctrl_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_ALU_LAST = 5'b01100;
    localparam logic [4:0] OP_MUL      = 5'b01111;
    localparam logic [4:0] OP_DIV      = 5'b10000;
    localparam logic [4:0] OP_NOP      = 5'b11010;
    localparam logic [4:0] OP_HALT     = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_HALT, S_STOPPED
    } state_e;

    typedef enum logic [1:0] {
        SEL_RA, SEL_RB, SEL_RC
    } sel_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MD, CLS_NOP, CLS_HALT, CLS_BAD
    } cls_e;

    function automatic cls_e op_class(input logic [4:0] op);
        if (op <= OP_ALU_LAST)
            return CLS_ALU;
        else if (op == OP_MUL || op == OP_DIV)
            return CLS_MD;
        else if (op == OP_NOP)
            return CLS_NOP;
        else if (op == OP_HALT)
            return CLS_HALT;
        else
            return CLS_BAD;
    endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Picks Ra/Rb/Rc and expands it to a gated one-hot
// register enable vector.
module reg_select_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic [3:0]      i_ra,
    input  logic [3:0]      i_rb,
    input  logic [3:0]      i_rc,
    input  sel_e            i_sel,
    input  logic            i_en,
    output logic [NREG-1:0] o_onehot
);

    logic [3:0] w_idx;

    always_comb begin
        w_idx = i_ra;
        case (i_sel)
            SEL_RB:  w_idx = i_rb;
            SEL_RC:  w_idx = i_rc;
            default: w_idx = i_ra;
        endcase
    end

    assign o_onehot = i_en
        ? ({{(NREG-1){1'b0}}, 1'b1} << w_idx)
        : '0;

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control FSM for the single-bus CPU datapath:
// fetch, decode and T3..T6 execute with memory/ALU handshakes.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_TIMEOUT = 64,
    parameter int NREG        = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            stop,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    input  logic            alu_done,
    output logic            PCout,
    output logic            ZHIout,
    output logic            ZLOout,
    output logic            MDRout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zhighin,
    output logic            Zlowin,
    output logic            HIin,
    output logic            LOin,
    output logic            IncPC,
    output logic            read,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [4:0]      operation,
    output logic            run,
    output logic            fault
);

    localparam int CW = $clog2(ALU_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(ALU_TIMEOUT - 1);

    state_e        r_state;
    logic [4:0]    r_op;
    logic [3:0]    r_ra;
    logic [3:0]    r_rb;
    logic [3:0]    r_rc;
    logic [CW-1:0] r_cnt;
    logic          r_fault;

    cls_e w_cls;
    logic w_rin_en;
    logic w_rout_en;
    sel_e w_rout_sel;
    logic w_unused_ir_lo;

    assign w_cls = op_class(r_op);
    assign w_unused_ir_lo = ^ir[14:0];
    assign fault = r_fault;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_RESET;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    if (mem_ready) r_state <= S_T2;
                S_T2: begin
                    r_op    <= ir[OP_MSB:OP_LSB];
                    r_ra    <= ir[RA_MSB:RA_LSB];
                    r_rb    <= ir[RB_MSB:RB_LSB];
                    r_rc    <= ir[RC_MSB:RC_LSB];
                    r_state <= S_T3;
                end
                S_T3: begin
                    case (w_cls)
                        CLS_ALU, CLS_MD: r_state <= S_T4;
                        CLS_NOP:  r_state <= stop ? S_STOPPED : S_T0;
                        CLS_HALT: r_state <= S_HALT;
                        default: begin
                            r_fault <= 1'b1;
                            r_state <= S_T0;
                        end
                    endcase
                end
                S_T4: begin
                    if (w_cls != CLS_MD) begin
                        r_state <= S_T5;
                    end else if (alu_done) begin
                        r_cnt   <= '0;
                        r_state <= S_T5;
                    end else if (r_cnt == CNT_MAX) begin
                        // Abandon the instruction: no result write-back
                        r_cnt   <= '0;
                        r_fault <= 1'b1;
                        r_state <= S_T0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_T5: begin
                    if (w_cls == CLS_MD)
                        r_state <= S_T6;
                    else
                        r_state <= stop ? S_STOPPED : S_T0;
                end
                S_T6:      r_state <= stop ? S_STOPPED : S_T0;
                S_STOPPED: if (!stop) r_state <= S_T0;
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        PCout      = 1'b0;
        ZHIout     = 1'b0;
        ZLOout     = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zhighin    = 1'b0;
        Zlowin     = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        read       = 1'b0;
        operation  = '0;
        run        = 1'b0;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_sel = SEL_RA;
        case (r_state)
            S_T0: begin
                run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                run    = 1'b1;
                ZLOout = 1'b1;
                read   = 1'b1;
                MDRin  = 1'b1;
                // Single PC load, only when the fetch completes
                PCin   = mem_ready;
            end
            S_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (w_cls == CLS_ALU) begin
                    w_rout_en  = 1'b1;
                    w_rout_sel = SEL_RB;
                    Yin        = 1'b1;
                end else if (w_cls == CLS_MD) begin
                    w_rout_en  = 1'b1;
                    w_rout_sel = SEL_RA;
                    Yin        = 1'b1;
                end
            end
            S_T4: begin
                run       = 1'b1;
                operation = r_op;
                Zlowin    = 1'b1;
                w_rout_en = 1'b1;
                if (w_cls == CLS_MD) begin
                    w_rout_sel = SEL_RB;
                    Zhighin    = 1'b1;
                end else begin
                    w_rout_sel = SEL_RC;
                end
            end
            S_T5: begin
                run    = 1'b1;
                ZLOout = 1'b1;
                if (w_cls == CLS_MD)
                    LOin = 1'b1;
                else
                    w_rin_en = 1'b1;
            end
            S_T6: begin
                run    = 1'b1;
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            default: begin
                run = 1'b0;
            end
        endcase
    end

    reg_select_decode #(.NREG(NREG)) u_rin (
        .i_ra     (r_ra),
        .i_rb     (r_rb),
        .i_rc     (r_rc),
        .i_sel    (SEL_RA),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

    reg_select_decode #(.NREG(NREG)) u_rout (
        .i_ra     (r_ra),
        .i_rb     (r_rb),
        .i_rc     (r_rc),
        .i_sel    (w_rout_sel),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

endmodule
